// File: rtl/bus_map_pkg.sv
// Address map of the core's data bus: region bounds (inclusive byte
// addresses) and the slave-select encoding shared by decoder and top.
package bus_map_pkg;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_SW,
        SEL_LEDS,
        SEL_7SEG,
        SEL_UA,
        SEL_UB,
        SEL_UC
    } bus_sel_e;

    // Every region is word-aligned, so comparing the full byte address
    // against inclusive bounds ignores addr[1:0] for free.
    localparam logic [31:0] RAM_BASE    = 32'h0000_1000;
    localparam logic [31:0] RAM_LIMIT   = 32'h0000_13FF;
    localparam logic [31:0] SW_BASE     = 32'h0000_2000;
    localparam logic [31:0] SW_LIMIT    = 32'h0000_2003;
    localparam logic [31:0] LEDS_BASE   = 32'h0000_2004;
    localparam logic [31:0] LEDS_LIMIT  = 32'h0000_2007;
    localparam logic [31:0] SEG_BASE    = 32'h0000_2008;
    localparam logic [31:0] SEG_LIMIT   = 32'h0000_200B;
    localparam logic [31:0] UA_BASE     = 32'h0000_2010;
    localparam logic [31:0] UA_LIMIT    = 32'h0000_201F;
    localparam logic [31:0] UB_BASE     = 32'h0000_2020;
    localparam logic [31:0] UB_LIMIT    = 32'h0000_202F;
    localparam logic [31:0] UC_BASE     = 32'h0000_2030;
    localparam logic [31:0] UC_LIMIT    = 32'h0000_203F;

    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address decoder: byte address to slave select.
// Anything outside the map (including nonzero addr[31:16]) selects SEL_NONE.
module bus_addr_decoder
    import bus_map_pkg::*;
(
    input  logic [31:0] addr_i,
    output bus_sel_e    sel_o
);

    always_comb begin
        sel_o = SEL_NONE;
        if (in_region(addr_i, RAM_BASE, RAM_LIMIT))        sel_o = SEL_RAM;
        else if (in_region(addr_i, SW_BASE, SW_LIMIT))     sel_o = SEL_SW;
        else if (in_region(addr_i, LEDS_BASE, LEDS_LIMIT)) sel_o = SEL_LEDS;
        else if (in_region(addr_i, SEG_BASE, SEG_LIMIT))   sel_o = SEL_7SEG;
        else if (in_region(addr_i, UA_BASE, UA_LIMIT))     sel_o = SEL_UA;
        else if (in_region(addr_i, UB_BASE, UB_LIMIT))     sel_o = SEL_UB;
        else if (in_region(addr_i, UC_BASE, UC_LIMIT))     sel_o = SEL_UC;
    end

endmodule

// File: rtl/conductor_de_bus.sv
// Data-bus conductor: same-cycle store-strobe routing to one slave, and a
// read mux steered by the select registered on the previous clock.
module conductor_de_bus
    import bus_map_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] do_ram_i,
    input  logic [31:0] do_switches_i,
    input  logic [31:0] do_uart_a_i,
    input  logic [31:0] do_uart_b_i,
    input  logic [31:0] do_uart_c_i,
    output logic        we_ram_o,
    output logic        we_leds_o,
    output logic        we_7seg_o,
    output logic        we_uart_a_o,
    output logic        we_uart_b_o,
    output logic        we_uart_c_o,
    output logic [31:0] d_out_o
);

    bus_sel_e sel_d;
    bus_sel_e sel_q;
    logic     wr_ok;

    bus_addr_decoder u_decoder (
        .addr_i (addr_i),
        .sel_o  (sel_d)
    );

    // Reset gates the strobe combinationally so a store in flight is killed.
    assign wr_ok       = we_i & rst_n_i;
    assign we_ram_o    = wr_ok & (sel_d == SEL_RAM);
    assign we_leds_o   = wr_ok & (sel_d == SEL_LEDS);
    assign we_7seg_o   = wr_ok & (sel_d == SEL_7SEG);
    assign we_uart_a_o = wr_ok & (sel_d == SEL_UA);
    assign we_uart_b_o = wr_ok & (sel_d == SEL_UB);
    assign we_uart_c_o = wr_ok & (sel_d == SEL_UC);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) sel_q <= SEL_NONE;
        else          sel_q <= sel_d;
    end

    // Slaves answer one cycle after the address, hence the registered select.
    always_comb begin
        d_out_o = 32'h0;
        case (sel_q)
            SEL_RAM: d_out_o = do_ram_i;
            SEL_SW:  d_out_o = do_switches_i;
            SEL_UA:  d_out_o = do_uart_a_i;
            SEL_UB:  d_out_o = do_uart_b_i;
            SEL_UC:  d_out_o = do_uart_c_i;
            default: d_out_o = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_conductor_de_bus.sv
// Directed bench for conductor_de_bus: write-enable routing, registered read
// mux, unmapped addresses, map boundaries and reset behaviour.
module tb_conductor_de_bus;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [31:0] addr;
    logic [31:0] do_ram, do_sw, do_ua, do_ub, do_uc;
    logic        we_ram, we_leds, we_7seg, we_ua, we_ub, we_uc;
    logic [31:0] d_out;
    logic [5:0]  we_vec;

    int pass_cnt = 0;
    int total_cnt = 0;

    // {ram, leds, 7seg, uart_a, uart_b, uart_c}
    assign we_vec = {we_ram, we_leds, we_7seg, we_ua, we_ub, we_uc};

    conductor_de_bus dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .we_i          (we),
        .addr_i        (addr),
        .do_ram_i      (do_ram),
        .do_switches_i (do_sw),
        .do_uart_a_i   (do_ua),
        .do_uart_b_i   (do_ub),
        .do_uart_c_i   (do_uc),
        .we_ram_o      (we_ram),
        .we_leds_o     (we_leds),
        .we_7seg_o     (we_7seg),
        .we_uart_a_o   (we_ua),
        .we_uart_b_o   (we_ub),
        .we_uart_c_o   (we_uc),
        .d_out_o       (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic [31:0] a, input logic w);
        @(negedge clk);
        addr = a;
        we   = w;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(32'h0000_1000, 1'b1);
        total_cnt++;
        if (we_vec !== 6'b000000) $display("FAIL reset_we: got %b want 000000", we_vec);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (d_out !== 32'h0) $display("FAIL reset_dout: got %h want 00000000", d_out);
        else pass_cnt++;
    endtask

    task automatic test_write_sweep();
        logic [31:0] a_t [8] = '{32'h1000, 32'h13FC, 32'h2000, 32'h2004,
                                 32'h2008, 32'h2010, 32'h2020, 32'h2030};
        logic [5:0]  w_t [8] = '{6'b100000, 6'b100000, 6'b000000, 6'b010000,
                                 6'b001000, 6'b000100, 6'b000010, 6'b000001};
        logic [31:0] d_t [8] = '{32'd10, 32'd10, 32'd20, 32'd0,
                                 32'd0, 32'd30, 32'd40, 32'd50};
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(a_t[i], 1'b1);
            total_cnt++;
            if (we_vec !== w_t[i])
                $display("FAIL write_we[%h]: got %b want %b", a_t[i], we_vec, w_t[i]);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (d_out !== d_t[i])
                $display("FAIL write_dout[%h]: got %0d want %0d", a_t[i], d_out, d_t[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reads();
        logic [31:0] a_t [7] = '{32'h2000, 32'h201C, 32'h2028, 32'h203C,
                                 32'h1004, 32'h2004, 32'h2008};
        logic [31:0] d_t [7] = '{32'd20, 32'd30, 32'd40, 32'd50,
                                 32'd10, 32'd0, 32'd0};
        for (int i = 0; i < 7; i++) begin
            drive(a_t[i], 1'b0);
            total_cnt++;
            if (we_vec !== 6'b000000)
                $display("FAIL read_we[%h]: got %b want 000000", a_t[i], we_vec);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (d_out !== d_t[i])
                $display("FAIL read_dout[%h]: got %0d want %0d", a_t[i], d_out, d_t[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] a_t [7] = '{32'h0000_0001, 32'h0000_1400, 32'h0000_200C,
                                 32'h0000_2040, 32'h0001_1000, 32'hFFFF_2004,
                                 32'h0000_0FFC};
        for (int i = 0; i < 7; i++) begin
            drive(a_t[i], 1'b1);
            total_cnt++;
            if (we_vec !== 6'b000000)
                $display("FAIL unmapped_we[%h]: got %b want 000000", a_t[i], we_vec);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (d_out !== 32'h0)
                $display("FAIL unmapped_dout[%h]: got %0d want 0", a_t[i], d_out);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        drive(32'h2010, 1'b0);
        tick();
        drive(32'h2020, 1'b0);
        // Select is still the previous address until the next rising edge.
        total_cnt++;
        if (d_out !== 32'd30) $display("FAIL b2b_hold: got %0d want 30", d_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (d_out !== 32'd40) $display("FAIL b2b_next: got %0d want 40", d_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        drive(32'h2030, 1'b1);
        total_cnt++;
        if (we_vec !== 6'b000001) $display("FAIL mid_pre_we: got %b want 000001", we_vec);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (we_vec !== 6'b000000) $display("FAIL mid_rst_we: got %b want 000000", we_vec);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (d_out !== 32'h0) $display("FAIL mid_rst_dout: got %0d want 0", d_out);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        we     = 1'b0;
        addr   = 32'h0;
        do_ram = 32'd10;
        do_sw  = 32'd20;
        do_ua  = 32'd30;
        do_ub  = 32'd40;
        do_uc  = 32'd50;
        test_reset();
        test_write_sweep();
        test_reads();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
